vga_timing_gen: RTL and testbench

- Source end of the pixel interface: generates the 640x480@60 Hz VGA raster timing and the pixel coordinates that the top-level colour logic consumes.
- Runs from the 50 MHz board clock. Emits the 25 MHz VGA_CLK, HS, VS, BLANK_N and SYNC_N, plus per-pixel x/y counts and frame/line strobes for game-state updates.
- Sync and blank outputs can be delayed so they line up with the registered RGB path downstream.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/sync_delay_line.sv | 39 +++
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants and sync level types
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Bundle carried through the delay line, msb first.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_n;
    } sync_t;

    // Inactive levels: syncs idle high, blanking asserted.
    localparam sync_t SYNC_RESET = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0};

    // Inclusive window test on a coordinate.
    function automatic logic in_window(input logic [COORD_W-1:0] v,
                                       input logic [COORD_W-1:0] lo,
                                       input logic [COORD_W-1:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - tick-enabled shift register aligning sync/blank with the pixel path
module sync_delay_line #(
    parameter int                 DEPTH     = 1,
    parameter int                 WIDTH     = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    // Shift one stage per pixel tick; hold otherwise.
    always_comb begin
        stage_d = stage_q;
        if (tick) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stage registers, cleared to the inactive levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {DEPTH{RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, sync/blank generation and line/frame strobes
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int PIPE_DELAY = 1
) (
    input  logic               clk,
    input  logic               rst,
    output logic               vga_clk,
    output logic [COORD_W-1:0] x_pixel,
    output logic [COORD_W-1:0] y_pixel,
    output logic               display_area,
    output logic               hsync,
    output logic               vsync,
    output logic               blank_n,
    output logic               sync_n,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] X_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] Y_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > (1 << COORD_W)) begin : g_h_total_check
        $error("vga_timing_gen: horizontal total does not fit the coordinate width");
    end
    if (V_TOTAL > (1 << COORD_W)) begin : g_v_total_check
        $error("vga_timing_gen: vertical total does not fit the coordinate width");
    end
    if ((PIPE_DELAY < 0) || (PIPE_DELAY > 3)) begin : g_delay_check
        $error("vga_timing_gen: PIPE_DELAY must be 0..3");
    end

    logic               phase_q, phase_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    logic  pix_tick;
    logic  x_wrap;
    logic  y_wrap;
    sync_t sync_raw;
    sync_t sync_out;

    assign pix_tick = phase_q;
    assign x_wrap   = (x_q == X_LAST);
    assign y_wrap   = (y_q == Y_LAST);

    // Next-state for the clock divider, raster counters and wrap strobes.
    always_comb begin
        phase_d       = ~phase_q;
        x_d           = x_q;
        y_d           = y_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_tick) begin
            if (x_wrap) begin
                x_d          = '0;
                line_start_d = 1'b1;
                if (y_wrap) begin
                    y_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Raster state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q       <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Undelayed sync/blank levels decoded from the current counts.
    always_comb begin
        display_area     = (x_q < X_ACT) && (y_q < Y_ACT);
        sync_raw.hsync   = ~in_window(x_q, HS_START, HS_END);
        sync_raw.vsync   = ~in_window(y_q, VS_START, VS_END);
        sync_raw.blank_n = display_area;
    end

    if (PIPE_DELAY == 0) begin : g_no_delay
        assign sync_out = sync_raw;
    end else begin : g_delay
        sync_delay_line #(
            .DEPTH     (PIPE_DELAY),
            .WIDTH     (3),
            .RESET_VAL (SYNC_RESET)
        ) u_sync_delay (
            .clk   (clk),
            .rst_n (rst),
            .tick  (pix_tick),
            .din   (sync_raw),
            .dout  (sync_out)
        );
    end

    assign vga_clk     = phase_q;
    assign x_pixel     = x_q;
    assign y_pixel     = y_q;
    assign hsync       = sync_out.hsync;
    assign vsync       = sync_out.vsync;
    assign blank_n     = sync_out.blank_n;
    assign sync_n      = 1'b0;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed vector bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    // Small raster: H_TOTAL=16 (hsync low x=10..12), V_TOTAL=10 (vsync low y=7..8),
    // active 8x6, frame = 160 ticks = 320 clk.
    logic       d0_vga_clk, d0_da, d0_hs, d0_vs, d0_bn, d0_sn, d0_ls, d0_fs;
    logic [9:0] d0_x, d0_y;
    logic       d3_vga_clk, d3_da, d3_hs, d3_vs, d3_bn, d3_sn, d3_ls, d3_fs;
    logic [9:0] d3_x, d3_y;
    logic       df_vga_clk, df_da, df_hs, df_vs, df_bn, df_sn, df_ls, df_fs;
    logic [9:0] df_x, df_y;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(0)
    ) u_d0 (
        .clk(clk), .rst(rst), .vga_clk(d0_vga_clk), .x_pixel(d0_x), .y_pixel(d0_y),
        .display_area(d0_da), .hsync(d0_hs), .vsync(d0_vs), .blank_n(d0_bn),
        .sync_n(d0_sn), .line_start(d0_ls), .frame_start(d0_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(3)
    ) u_d3 (
        .clk(clk), .rst(rst), .vga_clk(d3_vga_clk), .x_pixel(d3_x), .y_pixel(d3_y),
        .display_area(d3_da), .hsync(d3_hs), .vsync(d3_vs), .blank_n(d3_bn),
        .sync_n(d3_sn), .line_start(d3_ls), .frame_start(d3_fs)
    );

    vga_timing_gen #(.PIPE_DELAY(1)) u_df (
        .clk(clk), .rst(rst), .vga_clk(df_vga_clk), .x_pixel(df_x), .y_pixel(df_y),
        .display_area(df_da), .hsync(df_hs), .vsync(df_vs), .blank_n(df_bn),
        .sync_n(df_sn), .line_start(df_ls), .frame_start(df_fs)
    );

    typedef struct {
        int   n;
        int   x;
        int   y;
        logic hs, vs, bn, ls, fs, hs3, bn3;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    function automatic vec_t mk(int n, int x, int y, logic hs, logic vs, logic bn,
                                logic ls, logic fs, logic hs3, logic bn3);
        vec_t v;
        v.n = n; v.x = x; v.y = y; v.hs = hs; v.vs = vs; v.bn = bn;
        v.ls = ls; v.fs = fs; v.hs3 = hs3; v.bn3 = bn3;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " d0 x"}, d0_x, 0);
        chk({tag, " d0 y"}, d0_y, 0);
        chk({tag, " d0 vga_clk"}, d0_vga_clk, 0);
        chk({tag, " d0 hsync"}, d0_hs, 1);
        chk({tag, " d0 vsync"}, d0_vs, 1);
        chk({tag, " d0 line_start"}, d0_ls, 0);
        chk({tag, " d0 frame_start"}, d0_fs, 0);
        chk({tag, " d3 hsync"}, d3_hs, 1);
        chk({tag, " d3 vsync"}, d3_vs, 1);
        chk({tag, " d3 blank_n"}, d3_bn, 0);
        chk({tag, " df x"}, df_x, 0);
        chk({tag, " df y"}, df_y, 0);
        chk({tag, " df vga_clk"}, df_vga_clk, 0);
        chk({tag, " df hsync"}, df_hs, 1);
        chk({tag, " df vsync"}, df_vs, 1);
        chk({tag, " df blank_n"}, df_bn, 0);
        chk({tag, " df line_start"}, df_ls, 0);
        chk({tag, " df frame_start"}, df_fs, 0);
    endtask

    initial begin
        int   df_hs_low, df_bn_hi, df_da_hi, df_x656, df_hsf, df_ls_last, df_ls_period;
        int   d0_hsf, d3_hsf, d0_fs_last, d0_fs_period, d0_vs_low, dbl, found;
        int   vga_bad, fs_after;
        logic df_hs_prev, d0_hs_prev, d3_hs_prev;
        logic p_d0_ls, p_d0_fs, p_d3_ls, p_df_ls, p_df_fs;

        // n = clk edges since release; columns: x y hs vs bn ls fs (d0), hs bn (d3)
        vecs.push_back(mk(  1,  0, 0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(  2,  1, 0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(  4,  2, 0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(  6,  3, 0, 1, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk( 16,  8, 0, 1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk( 20, 10, 0, 0, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk( 22, 11, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk( 24, 12, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk( 26, 13, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk( 30, 15, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk( 32,  0, 1, 1, 1, 1, 1, 0, 1, 0));
        vecs.push_back(mk( 33,  0, 1, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk( 38,  3, 1, 1, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk(192,  0, 6, 1, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(224,  0, 7, 1, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(256,  0, 8, 1, 0, 0, 1, 0, 1, 0));
        vecs.push_back(mk(288,  0, 9, 1, 1, 0, 1, 0, 1, 0));
        vecs.push_back(mk(320,  0, 0, 1, 1, 1, 1, 1, 1, 0));
        vecs.push_back(mk(321,  0, 0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(322,  1, 0, 1, 1, 1, 0, 0, 1, 0));
        vecs.push_back(mk(326,  3, 0, 1, 1, 1, 0, 0, 1, 1));

        // Reset held for 5 clk
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_reset_state("reset");
        chk("reset sync_n", d0_sn, 0);

        @(negedge clk);
        rst = 1'b1;
        cyc = 0;

        // Table-driven raster vectors on the small rasters
        for (int i = 0; i < vecs.size(); i++) begin
            while (cyc < vecs[i].n) begin
                @(posedge clk);
                cyc++;
            end
            #1;
            chk($sformatf("n%0d x", cyc), d0_x, vecs[i].x);
            chk($sformatf("n%0d y", cyc), d0_y, vecs[i].y);
            chk($sformatf("n%0d vga_clk", cyc), d0_vga_clk, cyc % 2);
            chk($sformatf("n%0d hsync", cyc), d0_hs, vecs[i].hs);
            chk($sformatf("n%0d vsync", cyc), d0_vs, vecs[i].vs);
            chk($sformatf("n%0d blank_n", cyc), d0_bn, vecs[i].bn);
            chk($sformatf("n%0d display_area", cyc), d0_da, vecs[i].bn);
            chk($sformatf("n%0d line_start", cyc), d0_ls, vecs[i].ls);
            chk($sformatf("n%0d frame_start", cyc), d0_fs, vecs[i].fs);
            chk($sformatf("n%0d d3 x", cyc), d3_x, vecs[i].x);
            chk($sformatf("n%0d d3 hsync", cyc), d3_hs, vecs[i].hs3);
            chk($sformatf("n%0d d3 blank_n", cyc), d3_bn, vecs[i].bn3);
        end

        // Free-run through two default lines and several small frames
        df_hs_low = 0; df_bn_hi = 0; df_da_hi = 0; df_x656 = -1; df_hsf = -1;
        df_ls_last = -1; df_ls_period = -1; d0_hsf = -1; d3_hsf = -1;
        d0_fs_last = -1; d0_fs_period = -1; d0_vs_low = 0; dbl = 0;
        df_hs_prev = df_hs; d0_hs_prev = d0_hs; d3_hs_prev = d3_hs;
        p_d0_ls = d0_ls; p_d0_fs = d0_fs; p_d3_ls = d3_ls; p_df_ls = df_ls; p_df_fs = df_fs;
        while (cyc < 3202) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc >= 1600 && cyc < 3200 && cyc % 2 == 0) begin
                if (!df_hs) df_hs_low++;
                if (df_bn)  df_bn_hi++;
                if (df_da)  df_da_hi++;
            end
            if (cyc >= 640 && cyc < 960 && cyc % 2 == 0 && !d0_vs) d0_vs_low++;
            if (df_x == 10'd656 && df_x656 < 0) df_x656 = cyc;
            if (df_hs_prev && !df_hs && df_hsf < 0) df_hsf = cyc;
            if (d0_hs_prev && !d0_hs && d0_hsf < 0) d0_hsf = cyc;
            if (d3_hs_prev && !d3_hs && d3_hsf < 0) d3_hsf = cyc;
            if (df_ls) begin
                if (df_ls_last >= 0) df_ls_period = cyc - df_ls_last;
                df_ls_last = cyc;
            end
            if (d0_fs) begin
                if (d0_fs_last >= 0) d0_fs_period = cyc - d0_fs_last;
                d0_fs_last = cyc;
            end
            if (cyc == 1278) chk("df display_area x639", df_da, 1);
            if (cyc == 1280) chk("df display_area x640", df_da, 0);
            if ((p_d0_ls && d0_ls) || (p_d0_fs && d0_fs) || (p_d3_ls && d3_ls) ||
                (p_df_ls && df_ls) || (p_df_fs && df_fs)) dbl++;
            df_hs_prev = df_hs; d0_hs_prev = d0_hs; d3_hs_prev = d3_hs;
            p_d0_ls = d0_ls; p_d0_fs = d0_fs; p_d3_ls = d3_ls; p_df_ls = df_ls; p_df_fs = df_fs;
        end
        chk("df hsync low ticks per line", df_hs_low, 96);
        chk("df blank_n high ticks per line", df_bn_hi, 640);
        chk("df display_area ticks per line", df_da_hi, 640);
        chk("df hsync fall after x656 (clk)", df_hsf - df_x656, 2);
        chk("df line_start period", df_ls_period, 1600);
        chk("d0 frame_start period", d0_fs_period, 320);
        chk("d0 vsync low ticks per frame", d0_vs_low, 32);
        chk("d3 vs d0 hsync fall lag (clk)", d3_hsf - d0_hsf, 6);
        chk("strobe wider than 1 clk", dbl, 0);

        // Mid-frame asynchronous reset
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (d0_x == 10'd5 && d0_y == 10'd3) found = 1;
        end
        chk("reach x5 y3 before reset", found, 1);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_state("async reset");
        repeat (3) @(posedge clk);
        #1;
        chk("held reset x", d0_x, 0);
        chk("held reset vga_clk", d0_vga_clk, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        vga_bad = 0;
        fs_after = -1;
        while (cyc < 330) begin
            @(posedge clk);
            cyc++;
            #1;
            if (d0_vga_clk != cyc[0]) vga_bad++;
            if (cyc == 2) chk("after release x at edge 2", d0_x, 1);
            if (cyc == 1) chk("after release x at edge 1", d0_x, 0);
            if (d0_fs && fs_after < 0) fs_after = cyc;
            if (d0_ls && cyc < 32) chk("early line_start", cyc, 32);
        end
        chk("vga_clk toggle errors", vga_bad, 0);
        chk("first frame_start after reset", fs_after, 320);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
